pipe_reg: RTL and testbench

Parametrised elastic register pipeline, the successor to the single-rank flop bank. It carries a BUS_WIDTH-bit word through DEPTH register ranks using valid/ready handshakes on both sides. Each rank is a two-entry skid stage, so every ready is registered and no combinational path runs end to end. It also provides an inverted data output, a programmable reset value, a synchronous flush and an occupancy count. It sits between datapath blocks wherever timing closure needs retiming stages with back-pressure.

---
 rtl/pipe_reg_pkg.sv | 8 +
 rtl/pipe_reg_skid_stage.sv | 53 +++++
 rtl/pipe_reg.sv | 60 ++++++
 tb/tb_pipe_reg.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: shared datapath defaults and occupancy sizing for the elastic register pipeline
package pipe_reg_pkg;
  localparam int DEF_BUS_WIDTH = 8;
  localparam int DEF_DEPTH = 2;
  function automatic int occ_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction
endpackage

// File: rtl/pipe_reg_skid_stage.sv
// pipe_reg_skid_stage: two-entry skid register stage with registered upstream ready
// Ports: clk/rst_n (async active-low), i_flush clears contents; i_valid/o_ready/i_data upstream side;
// o_valid/i_ready/o_data downstream side; o_count = number of valid entries held (0..2).
module pipe_reg_skid_stage import pipe_reg_pkg::*; #(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter logic [BUS_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [BUS_WIDTH-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [BUS_WIDTH-1:0] o_data,
  output logic [1:0]           o_count
);
  logic                 r_main_v;
  logic                 r_skid_v;
  logic [BUS_WIDTH-1:0] r_main_d;
  logic [BUS_WIDTH-1:0] r_skid_d;
  logic                 w_take;
  logic                 w_pop;
  // ready depends only on the skid flag, so no combinational path crosses the stage
  assign o_ready = ~r_skid_v;
  assign w_take  = i_valid & ~r_skid_v;
  assign w_pop   = r_main_v & i_ready;
  assign o_valid = r_main_v;
  assign o_data  = r_main_d;
  assign o_count = {1'b0, r_main_v} + {1'b0, r_skid_v};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= RESET_VALUE;
      r_skid_d <= RESET_VALUE;
    end else if (i_flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= RESET_VALUE;
      r_skid_d <= RESET_VALUE;
    end else if (!r_main_v || w_pop) begin
      // main is free this edge: the older skid word has priority over a new arrival
      r_main_v <= r_skid_v | w_take;
      r_main_d <= r_skid_v ? r_skid_d : (w_take ? i_data : r_main_d);
      r_skid_v <= 1'b0;
    end else if (w_take) begin
      r_skid_v <= 1'b1;
      r_skid_d <= i_data;
    end
  end
endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: elastic valid/ready register pipeline of DEPTH skid stages
// Ports: clk, rst_n (async active-low), flush (sync clear); in_valid/in_ready/in_data upstream;
// out_valid/out_ready/out_data downstream, out_data_bar = ~out_data; occupancy = valid entries held.
module pipe_reg import pipe_reg_pkg::*; #(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [BUS_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BUS_WIDTH-1:0]     in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BUS_WIDTH-1:0]     out_data,
  output logic [BUS_WIDTH-1:0]     out_data_bar,
  output logic [occ_w(DEPTH)-1:0]  occupancy
);
  localparam int OW = occ_w(DEPTH);
  logic                 r_live;
  logic [DEPTH:0]       w_valid;
  logic [DEPTH:0]       w_ready;
  logic [BUS_WIDTH-1:0] w_data [DEPTH+1];
  logic [1:0]           w_cnt [DEPTH];
  // holds in_ready low through the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else r_live <= 1'b1;
  end
  assign in_ready     = w_ready[0] & r_live & ~flush;
  assign w_valid[0]   = in_valid & r_live & ~flush;
  assign w_data[0]    = in_data;
  assign w_ready[DEPTH] = out_ready;
  assign out_valid    = w_valid[DEPTH];
  assign out_data     = w_data[DEPTH];
  assign out_data_bar = ~w_data[DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_reg_skid_stage #(
      .BUS_WIDTH(BUS_WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .i_flush(flush),
      .i_valid(w_valid[g]),
      .o_ready(w_ready[g]),
      .i_data(w_data[g]),
      .o_valid(w_valid[g+1]),
      .i_ready(w_ready[g+1]),
      .o_data(w_data[g+1]),
      .o_count(w_cnt[g])
    );
  end
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OW'(w_cnt[k]);
  end
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: randomized scoreboard bench for pipe_reg (DEPTH=3 main instance, DEPTH=1 corner instance)
module tb_pipe_reg;
  logic clk = 0;
  logic rst_n = 1;
  logic flush = 0;
  logic in_valid = 0;
  logic out_ready = 0;
  logic in_ready, out_valid;
  logic [7:0] in_data = 0;
  logic [7:0] out_data, out_data_bar;
  logic [2:0] occupancy;
  logic d1_in_valid = 0, d1_out_ready = 0, d1_in_data = 0;
  logic d1_in_ready, d1_out_valid, d1_out_data, d1_out_data_bar;
  logic [1:0] d1_occ;
  int n_vec = 0, n_err = 0;
  int n_push = 0, n_pop = 0;
  bit mon_en = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  pipe_reg #(.BUS_WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_data_bar(out_data_bar), .occupancy(occupancy)
  );

  pipe_reg #(.BUS_WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
    .out_data_bar(d1_out_data_bar), .occupancy(d1_occ)
  );

  // Reference model: the pipe is a FIFO of words; occupancy is its length.
  always @(negedge clk) begin
    if (mon_en) begin
      n_vec++;
      if ({29'b0, occupancy} !== q.size()) begin
        n_err++;
        $display("FAIL mon_occupancy: got %0d want %0d", occupancy, q.size());
      end
      n_vec++;
      if (out_data_bar !== ~out_data) begin
        n_err++;
        $display("FAIL mon_bar: got %h want %h", out_data_bar, ~out_data);
      end
      if (out_valid) begin
        n_vec++;
        if (q.size() == 0 || out_data !== q[0]) begin
          n_err++;
          $display("FAIL mon_order: got %h want %h (model size %0d)", out_data, q.size() ? q[0] : 8'hxx, q.size());
        end
      end
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_err++;
          $display("FAIL mon_stall_stable: got v=%b d=%h want v=1 d=%h", out_valid, out_data, prev_data);
        end
      end
      if (flush) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL mon_flush_ready: got %b want 0", in_ready);
        end
      end
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) begin
        q.push_back(in_data);
        n_push++;
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_data = out_data;
    end else prev_stall = 0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst_n = 0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || occupancy !== 3'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: got v=%b r=%b occ=%0d want 0 0 0", out_valid, in_ready, occupancy);
    end
    n_vec++;
    if (out_data !== 8'hA5 || out_data_bar !== 8'h5A) begin
      n_err++;
      $display("FAIL reset_data: got %h/%h want a5/5a", out_data, out_data_bar);
    end
    n_vec++;
    if (d1_out_valid !== 1'b0 || d1_in_ready !== 1'b0 || d1_occ !== 2'd0 || d1_out_data !== 1'b1 || d1_out_data_bar !== 1'b0) begin
      n_err++;
      $display("FAIL reset_d1: got v=%b r=%b occ=%0d d=%b db=%b want 0 0 0 1 0", d1_out_valid, d1_in_ready, d1_occ, d1_out_data, d1_out_data_bar);
    end
    repeat (2) tick;
    rst_n = 1;
    #2;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL release_early_ready: got %b want 0", in_ready);
    end
    tick;
    n_vec++;
    if (in_ready !== 1'b1 || d1_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL release_ready: got %b/%b want 1/1", in_ready, d1_in_ready);
    end
    mon_en = 1;
  endtask

  task automatic test_passthrough;
    out_ready = 1;
    for (int j = 0; j < 20; j++) begin
      in_valid = j < 16;
      in_data = 8'(j + 1);
      if (j < 16) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL pt_ready: cycle %0d got %b want 1", j, in_ready);
        end
      end
      tick;
      n_vec++;
      if (out_valid !== (j >= 2 && j < 18) || (out_valid && out_data !== 8'(j - 1))) begin
        n_err++;
        $display("FAIL pt_out: edge %0d got v=%b d=%h want v=%b d=%h", j, out_valid, out_data, j >= 2 && j < 18, 8'(j - 1));
      end
    end
    in_valid = 0;
  endtask

  task automatic test_fill;
    int acc = 0;
    logic [7:0] want[$];
    out_ready = 0;
    in_valid = 1;
    for (int j = 0; j < 12; j++) begin
      in_data = 8'($urandom);
      if (in_ready) begin
        acc++;
        want.push_back(in_data);
      end
      tick;
    end
    in_valid = 0;
    n_vec++;
    if (acc != 6 || occupancy !== 3'd6 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL fill_capacity: got acc=%0d occ=%0d r=%b v=%b want 6 6 0 1", acc, occupancy, in_ready, out_valid);
    end
    out_ready = 1;
    for (int j = 0; j < 6; j++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== (want.size() > j ? want[j] : 8'hxx)) begin
        n_err++;
        $display("FAIL fill_drain: word %0d got v=%b d=%h want v=1 d=%h", j, out_valid, out_data, want.size() > j ? want[j] : 8'hxx);
      end
      tick;
    end
    n_vec++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      n_err++;
      $display("FAIL fill_empty: got v=%b occ=%0d want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_random;
    int cyc = 0;
    int p0 = n_push;
    int o0 = n_pop;
    while (n_push - p0 < 1000 && cyc < 20000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick;
      cyc++;
    end
    in_valid = 0;
    out_ready = 1;
    for (int j = 0; j < 40 && q.size() != 0; j++) tick;
    tick;
    n_vec++;
    if (cyc >= 20000 || q.size() != 0 || n_pop - o0 != n_push - p0 || n_push - p0 != 1000) begin
      n_err++;
      $display("FAIL random_bal: got pushed=%0d popped=%0d left=%0d cyc=%0d want 1000 1000 0", n_push - p0, n_pop - o0, q.size(), cyc);
    end
  endtask

  task automatic test_flush;
    out_ready = 0;
    in_valid = 1;
    for (int j = 0; j < 10 && occupancy != 3'd4; j++) begin
      in_data = 8'($urandom);
      tick;
    end
    n_vec++;
    if (occupancy !== 3'd4) begin
      n_err++;
      $display("FAIL flush_setup: got occ=%0d want 4", occupancy);
    end
    flush = 1;
    in_data = 8'h3C;
    out_ready = 1;
    tick;
    flush = 0;
    in_valid = 0;
    n_vec++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'hA5 || out_data_bar !== 8'h5A) begin
      n_err++;
      $display("FAIL flush_clear: got occ=%0d v=%b d=%h db=%h want 0 0 a5 5a", occupancy, out_valid, out_data, out_data_bar);
    end
    for (int j = 0; j < 5; j++) begin
      tick;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_discard: got v=%b d=%h want v=0", out_valid, out_data);
      end
    end
  endtask

  task automatic test_async_reset;
    out_ready = 0;
    in_valid = 1;
    for (int j = 0; j < 10 && occupancy != 3'd3; j++) begin
      in_data = 8'($urandom);
      tick;
    end
    in_valid = 0;
    n_vec++;
    if (occupancy !== 3'd3) begin
      n_err++;
      $display("FAIL areset_setup: got occ=%0d want 3", occupancy);
    end
    @(negedge clk);
    #2;
    mon_en = 0;
    rst_n = 0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || in_ready !== 1'b0 || out_data !== 8'hA5) begin
      n_err++;
      $display("FAIL areset_now: got v=%b occ=%0d r=%b d=%h want 0 0 0 a5", out_valid, occupancy, in_ready, out_data);
    end
    tick;
    rst_n = 1;
    q.delete();
    tick;
    mon_en = 1;
    out_ready = 1;
    for (int j = 0; j < 8; j++) begin
      in_valid = 1;
      in_data = 8'($urandom);
      tick;
    end
    in_valid = 0;
    repeat (6) tick;
    n_vec++;
    if (occupancy !== 3'd0 || q.size() != 0) begin
      n_err++;
      $display("FAIL areset_resume: got occ=%0d left=%0d want 0 0", occupancy, q.size());
    end
  endtask

  task automatic test_depth1;
    d1_out_ready = 0;
    d1_in_valid = 1;
    d1_in_data = 1;
    tick;
    n_vec++;
    if (d1_out_valid !== 1'b1 || d1_out_data !== 1'b1 || d1_occ !== 2'd1) begin
      n_err++;
      $display("FAIL d1_latency: got v=%b d=%b occ=%0d want 1 1 1", d1_out_valid, d1_out_data, d1_occ);
    end
    d1_in_data = 0;
    tick;
    n_vec++;
    if (d1_occ !== 2'd2 || d1_in_ready !== 1'b0 || d1_out_data !== 1'b1 || d1_out_data_bar !== 1'b0) begin
      n_err++;
      $display("FAIL d1_full: got occ=%0d r=%b d=%b db=%b want 2 0 1 0", d1_occ, d1_in_ready, d1_out_data, d1_out_data_bar);
    end
    d1_in_data = 1;
    tick;
    n_vec++;
    if (d1_occ !== 2'd2 || d1_out_data !== 1'b1) begin
      n_err++;
      $display("FAIL d1_hold: got occ=%0d d=%b want 2 1", d1_occ, d1_out_data);
    end
    d1_out_ready = 1;
    tick;
    n_vec++;
    if (d1_occ !== 2'd1 || d1_out_data !== 1'b0 || d1_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL d1_pop: got occ=%0d d=%b r=%b want 1 0 1", d1_occ, d1_out_data, d1_in_ready);
    end
    tick;
    n_vec++;
    if (d1_occ !== 2'd1 || d1_out_data !== 1'b1 || d1_out_data_bar !== 1'b0) begin
      n_err++;
      $display("FAIL d1_pushpop: got occ=%0d d=%b db=%b want 1 1 0", d1_occ, d1_out_data, d1_out_data_bar);
    end
    d1_in_data = 0;
    tick;
    n_vec++;
    if (d1_occ !== 2'd1 || d1_out_data !== 1'b0) begin
      n_err++;
      $display("FAIL d1_pushpop2: got occ=%0d d=%b want 1 0", d1_occ, d1_out_data);
    end
    d1_in_valid = 0;
    tick;
    n_vec++;
    if (d1_occ !== 2'd0 || d1_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL d1_empty: got occ=%0d v=%b want 0 0", d1_occ, d1_out_valid);
    end
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_fill;
    test_random;
    test_flush;
    test_async_reset;
    test_depth1;
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
